// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline hazard inputs and the PC / pipeline-register
// hold and clear lines. The pipeline side is the master, the controller the slave.
interface pipe_hazard_ctrl_if;
  logic [4:0] Rs_ID;
  logic [4:0] Rt_ID;
  logic       UsesRt_ID;
  logic [4:0] Rd_Ex;
  logic       RegWr_Ex;
  logic       MemtoReg_Ex;
  logic [1:0] PCSource;
  logic       mem_busy;

  logic       Keep;
  logic       Keep_IF_ID;
  logic       Keep_ID_Ex;
  logic       Keep_Ex_Mem;
  logic       Keep_Mem_Wr;
  logic       Reset_IF_ID;
  logic       Reset_ID_Ex;
  logic       Reset_Ex_Mem;
  logic       Reset_Mem_Wr;

  modport master (
    output Rs_ID, Rt_ID, UsesRt_ID, Rd_Ex, RegWr_Ex, MemtoReg_Ex, PCSource, mem_busy,
    input  Keep, Keep_IF_ID, Keep_ID_Ex, Keep_Ex_Mem, Keep_Mem_Wr,
    input  Reset_IF_ID, Reset_ID_Ex, Reset_Ex_Mem, Reset_Mem_Wr
  );

  modport slave (
    input  Rs_ID, Rt_ID, UsesRt_ID, Rd_Ex, RegWr_Ex, MemtoReg_Ex, PCSource, mem_busy,
    output Keep, Keep_IF_ID, Keep_ID_Ex, Keep_Ex_Mem, Keep_Mem_Wr,
    output Reset_IF_ID, Reset_ID_Ex, Reset_Ex_Mem, Reset_Mem_Wr
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage MIPS pipeline.
// Hold/clear lines are decided combinationally from the current inputs so the
// pipeline registers react at the same edge; state, counters and the freeze
// watchdog are registered.
module pipe_hazard_ctrl #(
  parameter int CNT_W        = 16,
  parameter int FREEZE_LIMIT = 64
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic [CNT_W-1:0]   freeze_cnt,
  output logic               timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    FREEZE   = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  localparam int             RUN_W   = $clog2(FREEZE_LIMIT + 1);
  localparam logic [RUN_W-1:0] LIMIT_V = RUN_W'(FREEZE_LIMIT);

  state_t           r_state;
  state_t           w_decision;
  logic             w_lu;
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;
  logic [CNT_W-1:0] r_freezeCnt;
  logic [RUN_W-1:0] r_freezeRun;
  logic [RUN_W-1:0] w_freezeRunNext;
  logic             r_timeout;

  // A load in Ex feeding a source of the ID instruction; $zero never hazards.
  assign w_lu = bus.MemtoReg_Ex & bus.RegWr_Ex & (bus.Rd_Ex != 5'd0) &
                ((bus.Rd_Ex == bus.Rs_ID) | (bus.UsesRt_ID & (bus.Rd_Ex == bus.Rt_ID)));

  // Priority decision and Mealy hold/clear lines: reset, freeze, redirect, stall, run.
  always_comb begin
    w_decision       = RUN;
    bus.Keep         = 1'b0;
    bus.Keep_IF_ID   = 1'b0;
    bus.Keep_ID_Ex   = 1'b0;
    bus.Keep_Ex_Mem  = 1'b0;
    bus.Keep_Mem_Wr  = 1'b0;
    bus.Reset_IF_ID  = 1'b0;
    bus.Reset_ID_Ex  = 1'b0;
    bus.Reset_Ex_Mem = 1'b0;
    bus.Reset_Mem_Wr = 1'b0;
    if (reset) begin
      bus.Reset_IF_ID  = 1'b1;
      bus.Reset_ID_Ex  = 1'b1;
      bus.Reset_Ex_Mem = 1'b1;
      bus.Reset_Mem_Wr = 1'b1;
    end else if (bus.mem_busy) begin
      w_decision      = FREEZE;
      bus.Keep        = 1'b1;
      bus.Keep_IF_ID  = 1'b1;
      bus.Keep_ID_Ex  = 1'b1;
      bus.Keep_Ex_Mem = 1'b1;
      bus.Keep_Mem_Wr = 1'b1;
    end else if (bus.PCSource != 2'b00) begin
      w_decision       = REDIRECT;
      bus.Reset_IF_ID  = 1'b1;
      bus.Reset_ID_Ex  = 1'b1;
      bus.Reset_Ex_Mem = 1'b1;
    end else if (w_lu) begin
      w_decision      = STALL;
      bus.Keep        = 1'b1;
      bus.Keep_IF_ID  = 1'b1;
      bus.Reset_ID_Ex = 1'b1;
    end
  end

  // Record the decision of this cycle as the visible state.
  always_ff @(posedge clk) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_decision;
  end

  // Saturating event counters, one per non-RUN decision kind.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stallCnt  <= '0;
      r_flushCnt  <= '0;
      r_freezeCnt <= '0;
    end else begin
      if (w_decision == STALL && r_stallCnt != '1)
        r_stallCnt <= r_stallCnt + 1'b1;
      if (w_decision == REDIRECT && r_flushCnt != '1)
        r_flushCnt <= r_flushCnt + 1'b1;
      if (w_decision == FREEZE && r_freezeCnt != '1)
        r_freezeCnt <= r_freezeCnt + 1'b1;
    end
  end

  // Length of the current unbroken freeze, held at the limit once reached.
  always_comb begin
    w_freezeRunNext = '0;
    if (w_decision == FREEZE) begin
      if (r_freezeRun != LIMIT_V) w_freezeRunNext = r_freezeRun + 1'b1;
      else                        w_freezeRunNext = r_freezeRun;
    end
  end

  // Watchdog: run length and sticky timeout, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_freezeRun <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_freezeRun <= w_freezeRunNext;
      if (w_freezeRunNext == LIMIT_V) r_timeout <= 1'b1;
    end
  end

  assign state      = r_state;
  assign stall_cnt  = r_stallCnt;
  assign flush_cnt  = r_flushCnt;
  assign freeze_cnt = r_freezeCnt;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with small counters and a short watchdog.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W        = 2;
  localparam int FREEZE_LIMIT = 4;

  // Control vector: {Keep, Keep_IF_ID, Keep_ID_Ex, Keep_Ex_Mem, Keep_Mem_Wr,
  //                  Reset_IF_ID, Reset_ID_Ex, Reset_Ex_Mem, Reset_Mem_Wr}
  localparam logic [8:0] CTL_RUN      = 9'b0_0000_0000;
  localparam logic [8:0] CTL_STALL    = 9'b1_1000_0100;
  localparam logic [8:0] CTL_FREEZE   = 9'b1_1111_0000;
  localparam logic [8:0] CTL_REDIRECT = 9'b0_0000_1110;
  localparam logic [8:0] CTL_RESET    = 9'b0_0000_1111;

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_STALL    = 2'd1;
  localparam logic [1:0] S_FREEZE   = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] freeze_cnt;
  logic             timeout;
  logic [8:0]       ctlOut;

  int checkCount = 0;
  int errorCount = 0;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(
    .CNT_W       (CNT_W),
    .FREEZE_LIMIT(FREEZE_LIMIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state     (state),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .freeze_cnt(freeze_cnt),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  assign ctlOut = {bus.Keep, bus.Keep_IF_ID, bus.Keep_ID_Ex, bus.Keep_Ex_Mem, bus.Keep_Mem_Wr,
                   bus.Reset_IF_ID, bus.Reset_ID_Ex, bus.Reset_Ex_Mem, bus.Reset_Mem_Wr};

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 'h%0h expected 'h%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's worth of inputs.
  task automatic applyStimulus(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                               input logic usesRt, input logic [4:0] rd, input logic regWr,
                               input logic memToReg, input logic [1:0] pcSrc, input logic busy);
    reset           = rst;
    bus.Rs_ID       = rs;
    bus.Rt_ID       = rt;
    bus.UsesRt_ID   = usesRt;
    bus.Rd_Ex       = rd;
    bus.RegWr_Ex    = regWr;
    bus.MemtoReg_Ex = memToReg;
    bus.PCSource    = pcSrc;
    bus.mem_busy    = busy;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  // Check the combinational controls mid-cycle, then the registered state after the edge.
  task automatic stepCheck(input string tag, input logic [8:0] expCtl, input logic [1:0] expState);
    @(negedge clk);
    checkOutput({tag, "_ctl"}, int'(ctlOut), int'(expCtl));
    @(posedge clk);
    #1;
    checkOutput({tag, "_state"}, int'(state), int'(expState));
  endtask

  task automatic checkCounters(input string tag, input int expStall, input int expFlush,
                               input int expFreeze, input int expTimeout);
    checkOutput({tag, "_stallCnt"}, int'(stall_cnt), expStall);
    checkOutput({tag, "_flushCnt"}, int'(flush_cnt), expFlush);
    checkOutput({tag, "_freezeCnt"}, int'(freeze_cnt), expFreeze);
    checkOutput({tag, "_timeout"}, int'(timeout), expTimeout);
  endtask

  initial begin
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);
    @(posedge clk);
    #1;

    stepCheck("reset", CTL_RESET, S_RUN);
    checkCounters("reset", 0, 0, 0, 0);

    applyStimulus(1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 2'b00, 1'b0);
    stepCheck("luRs", CTL_STALL, S_STALL);
    checkOutput("luRs_stallCnt", int'(stall_cnt), 1);

    applyIdle();
    stepCheck("idle1", CTL_RUN, S_RUN);

    applyStimulus(1'b0, 5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b1, 2'b00, 1'b0);
    stepCheck("rtUnused", CTL_RUN, S_RUN);
    checkOutput("rtUnused_stallCnt", int'(stall_cnt), 1);

    applyStimulus(1'b0, 5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 2'b00, 1'b0);
    stepCheck("rtUsed", CTL_STALL, S_STALL);
    checkOutput("rtUsed_stallCnt", int'(stall_cnt), 2);

    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 2'b00, 1'b0);
    stepCheck("rdZero", CTL_RUN, S_RUN);
    checkOutput("rdZero_stallCnt", int'(stall_cnt), 2);

    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0);
    stepCheck("redirect", CTL_REDIRECT, S_REDIRECT);
    checkOutput("redirect_flushCnt", int'(flush_cnt), 1);

    applyStimulus(1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 2'b01, 1'b0);
    stepCheck("redirLu", CTL_REDIRECT, S_REDIRECT);
    checkCounters("redirLu", 2, 2, 0, 0);

    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);
    stepCheck("reset2", CTL_RESET, S_RUN);
    checkCounters("reset2", 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b10, 1'b1);
      stepCheck("frzBranch", CTL_FREEZE, S_FREEZE);
    end
    checkCounters("frzHeld", 0, 0, 3, 0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b10, 1'b0);
    stepCheck("frzRelease", CTL_REDIRECT, S_REDIRECT);
    checkCounters("frzRelease", 0, 1, 3, 0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b1);
      stepCheck("frzSplit", CTL_FREEZE, S_FREEZE);
    end
    applyIdle();
    stepCheck("frzSplitEnd", CTL_RUN, S_RUN);
    checkCounters("frzSplit", 0, 1, 3, 0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b1);
      stepCheck("wdog", CTL_FREEZE, S_FREEZE);
    end
    checkOutput("wdog3_timeout", int'(timeout), 0);
    stepCheck("wdog4", CTL_FREEZE, S_FREEZE);
    checkOutput("wdog4_timeout", int'(timeout), 1);
    applyIdle();
    stepCheck("wdogDrop1", CTL_RUN, S_RUN);
    stepCheck("wdogDrop2", CTL_RUN, S_RUN);
    checkOutput("wdogSticky_timeout", int'(timeout), 1);

    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b1);
    stepCheck("preRstFrz", CTL_FREEZE, S_FREEZE);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b1);
    stepCheck("rstInFrz", CTL_RESET, S_RUN);
    checkCounters("rstInFrz", 0, 0, 0, 0);
    applyIdle();
    stepCheck("postRst", CTL_RUN, S_RUN);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 2'b00, 1'b0);
      stepCheck("satStall", CTL_STALL, S_STALL);
    end
    checkCounters("sat", 3, 0, 0, 0);

    applyIdle();
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
